// File: rtl/if_id_fetch_queue_pkg.sv
// Shared constants for the IF/ID fetch queue.
//   FQ_DATA_W     : width of the PC and instruction fields
//   FQ_NOP_INST   : instruction word presented to ID when the queue is empty
//   FETCH_Q_DEPTH : default number of queue entries
//   ptr_width()   : pointer width for a given power-of-two depth
package if_id_fetch_queue_pkg;

    localparam int unsigned FQ_DATA_W     = 32;
    localparam logic [FQ_DATA_W-1:0] FQ_NOP_INST = '0;
    localparam int unsigned FETCH_Q_DEPTH = 4;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/if_id_fetch_queue_ptr.sv
// Wrapping queue pointer.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (pointer -> 0)
//   clr  : synchronous clear, wins over inc
//   inc  : advance pointer by one, wrapping modulo 2**PTR_W
//   ptr  : current pointer value
module fetch_q_ptr #(
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: buffers {PC+4, Inst} pairs from the IF stage and hands
// them to ID in order over a valid/ready handshake. Replaces a plain IF/ID
// register while decoupling ID stalls from fetch.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   Branch_taken    : flush; queued entries and this cycle's fetch are discarded
//   if_valid/if_PC/if_Inst : fetched instruction from IF
//   freeze          : to IF, hold PC (high exactly when the queue is full)
//   id_ready        : ID accepts the head entry this cycle
//   id_valid/id_PC/id_Inst : head entry to ID (PC=0, Inst=NOP when empty)
//   count           : occupancy, 0..DEPTH
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = FETCH_Q_DEPTH,
    parameter int unsigned PTR_W  = ptr_width(FETCH_Q_DEPTH),
    parameter int unsigned DATA_W = FQ_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Branch_taken,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_PC,
    input  logic [DATA_W-1:0] if_Inst,
    output logic              freeze,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_PC,
    output logic [DATA_W-1:0] id_Inst,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] pc_mem_q   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A flush discards both transfers of its cycle.
    assign push = if_valid & ~full & ~Branch_taken;
    assign pop  = ~empty & id_ready & ~Branch_taken;

    fetch_q_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (Branch_taken),
        .inc (push),
        .ptr (wr_ptr)
    );

    fetch_q_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (Branch_taken),
        .inc (pop),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (Branch_taken) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is never reset; empty-queue outputs are masked below instead.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr]   <= if_PC;
            inst_mem_q[wr_ptr] <= if_Inst;
        end
    end

    assign freeze   = full;
    assign id_valid = ~empty;
    assign id_PC    = empty ? '0 : pc_mem_q[rd_ptr];
    assign id_Inst  = empty ? DATA_W'(FQ_NOP_INST) : inst_mem_q[rd_ptr];
    assign count    = count_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed self-checking bench for if_id_fetch_queue (DEPTH=4).
module tb_if_id_fetch_queue;

    logic        clk;
    logic        rst;
    logic        Branch_taken;
    logic        if_valid;
    logic [31:0] if_PC;
    logic [31:0] if_Inst;
    logic        freeze;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_PC;
    logic [31:0] id_Inst;
    logic [2:0]  count;

    int unsigned n_vec;
    int unsigned n_err;

    if_id_fetch_queue #(
        .DEPTH  (4),
        .PTR_W  (2),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Branch_taken (Branch_taken),
        .if_valid     (if_valid),
        .if_PC        (if_PC),
        .if_Inst      (if_Inst),
        .freeze       (freeze),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_PC        (id_PC),
        .id_Inst      (id_Inst),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs for the next edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic br);
        if_valid     = v;
        if_PC        = pc;
        if_Inst      = inst_of(pc);
        id_ready     = rdy;
        Branch_taken = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int unsigned cnt, input logic frz);
        chk({tag, ".count"},  {29'd0, count}, cnt);
        chk({tag, ".freeze"}, {31'd0, freeze}, {31'd0, frz});
    endtask

    // Head check; an empty head must be the PC=0 / NOP bubble.
    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
        chk({tag, ".id_PC"},    id_PC,   v ? pc : 32'd0);
        chk({tag, ".id_Inst"},  id_Inst, v ? inst_of(pc) : 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #12;
        chk_state("reset", 0, 1'b0);
        chk_head("reset", 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Streaming: one-cycle IF->ID latency, occupancy stays at 1.
        drive(1'b1, 32'd4, 1'b1, 1'b0);  step();
        chk_state("stream1", 1, 1'b0); chk_head("stream1", 1'b1, 32'd4);
        drive(1'b1, 32'd8, 1'b1, 1'b0);  step();
        chk_state("stream2", 1, 1'b0); chk_head("stream2", 1'b1, 32'd8);
        drive(1'b1, 32'd12, 1'b1, 1'b0); step();
        chk_state("stream3", 1, 1'b0); chk_head("stream3", 1'b1, 32'd12);
        drive(1'b0, 32'd0, 1'b1, 1'b0);  step();
        chk_state("stream_end", 0, 1'b0); chk_head("stream_end", 1'b0, 32'd0);

        // Fill with ID stalled (pointers start at 3, so this wraps).
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0); step();
            chk_state($sformatf("fill%0d", i), i, i == 4);
            chk_head($sformatf("fill%0d", i), 1'b1, 32'd4);
        end
        drive(1'b1, 32'd20, 1'b0, 1'b0); step();
        chk_state("fill_rejected", 4, 1'b1); chk_head("fill_rejected", 1'b1, 32'd4);
        drive(1'b0, 32'd0, 1'b1, 1'b0); step();
        chk_state("drain1", 3, 1'b0); chk_head("drain1", 1'b1, 32'd8);
        step(); chk_state("drain2", 2, 1'b0); chk_head("drain2", 1'b1, 32'd12);
        step(); chk_state("drain3", 1, 1'b0); chk_head("drain3", 1'b1, 32'd16);
        step(); chk_state("drain4", 0, 1'b0); chk_head("drain4", 1'b1 ^ 1'b1, 32'd0);

        // Full + pop: the offered word is rejected, one slot frees.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0); step();
        end
        chk_state("fullpop_pre", 4, 1'b1);
        drive(1'b1, 32'h50, 1'b1, 1'b0); step();
        chk_state("fullpop", 3, 1'b0); chk_head("fullpop", 1'b1, 32'h44);
        drive(1'b0, 32'd0, 1'b1, 1'b0); step();
        chk_head("fullpop_d1", 1'b1, 32'h48);
        step(); chk_head("fullpop_d2", 1'b1, 32'h4C);
        step(); chk_state("fullpop_end", 0, 1'b0); chk_head("fullpop_end", 1'b0, 32'd0);

        // Wrap: 6 pushes / 6 pops interleaved across the pointer wrap.
        drive(1'b1, 32'h200, 1'b0, 1'b0); step();
        chk_state("wrap_a", 1, 1'b0); chk_head("wrap_a", 1'b1, 32'h200);
        drive(1'b1, 32'h204, 1'b0, 1'b0); step();
        chk_state("wrap_b", 2, 1'b0); chk_head("wrap_b", 1'b1, 32'h200);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h208 + 32'(4 * i), 1'b1, 1'b0); step();
            chk_state($sformatf("wrap_pp%0d", i), 2, 1'b0);
            chk_head($sformatf("wrap_pp%0d", i), 1'b1, 32'h204 + 32'(4 * i));
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0); step();
        chk_state("wrap_p1", 1, 1'b0); chk_head("wrap_p1", 1'b1, 32'h214);
        step();
        chk_state("wrap_end", 0, 1'b0); chk_head("wrap_end", 1'b0, 32'd0);

        // Flush with count=3 while IF offers and ID accepts.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0); step();
        end
        chk_state("flush_pre", 3, 1'b0); chk_head("flush_pre", 1'b1, 32'h300);
        drive(1'b1, 32'h30C, 1'b1, 1'b1); step();
        chk_state("flush", 0, 1'b0); chk_head("flush", 1'b0, 32'd0);
        drive(1'b1, 32'h100, 1'b0, 1'b0); step();
        chk_state("flush_target", 1, 1'b0); chk_head("flush_target", 1'b1, 32'h100);
        drive(1'b0, 32'd0, 1'b1, 1'b0); step();
        chk_state("flush_end", 0, 1'b0);

        // Asynchronous reset mid-stream with count=3.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0); step();
        end
        chk_state("arst_pre", 3, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_state("arst", 0, 1'b0); chk_head("arst", 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h600, 1'b0, 1'b0); step();
        chk_state("arst_after", 1, 1'b0); chk_head("arst_after", 1'b1, 32'h600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
